alu: RTL and testbench

//  32-bit registered ALU for the KGP-miniRISC datapath (execute stage).

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shifter.sv | 54 +++++
 rtl/alu.sv | 151 +++++++++++++++
 tb/tb_alu.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants and types for the KGP-miniRISC execute-stage
//                ALU. Holds the datapath width, the 4-bit ALUSel opcode map
//                and the barrel-shifter mode encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Datapath width. Flag generation and the 5-bit shift amount assume 32.
    localparam int WIDTH = 32;

    // ALUSel opcode map
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_COMP = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SHLL = 4'b0100;
    localparam logic [3:0] ALU_SHRL = 4'b0101;
    localparam logic [3:0] ALU_SHRA = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_DIFF = 4'b1001;

    // Barrel-shifter direction / fill mode
    typedef enum logic [1:0] {
        SH_LL = 2'd0,   // logical left
        SH_RL = 2'd1,   // logical right, zero fill
        SH_RA = 2'd2    // arithmetic right, sign fill
    } shift_mode_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shifter
//  Description : Combinational 32-bit barrel shifter with shifted-out bit.
//                Ports:
//                  a        in  [WIDTH-1:0]  value to shift
//                  amount   in  [4:0]        shift distance 0..31
//                  mode     in  shift_mode_t LL / RL / RA
//                  shifted  out [WIDTH-1:0]  shifted value
//                  out_bit  out 1            last bit shifted out (0 if amount==0)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [4:0]       amount,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] shifted,
    output logic             out_bit
);

    // Each shift runs on a 33-bit vector with one guard bit on the side the
    // data leaves from. After the shift the guard position holds exactly the
    // last bit pushed out, and a zero amount leaves the (zero) guard in place.
    logic [WIDTH:0] w_ll;
    logic [WIDTH:0] w_rl;
    logic [WIDTH:0] w_ra;

    assign w_ll = {1'b0, a} << amount;
    assign w_rl = {a, 1'b0} >> amount;
    assign w_ra = $signed({a, 1'b0}) >>> amount;

    always_comb begin
        shifted = w_ll[WIDTH-1:0];
        out_bit = w_ll[WIDTH];
        case (mode)
            SH_RL: begin
                shifted = w_rl[WIDTH:1];
                out_bit = w_rl[0];
            end
            SH_RA: begin
                shifted = w_ra[WIDTH:1];
                out_bit = w_ra[0];
            end
            default: begin
                shifted = w_ll[WIDTH-1:0];
                out_bit = w_ll[WIDTH];
            end
        endcase
    end

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 32-bit registered ALU for the KGP-miniRISC execute stage.
//                One-cycle latency, one result per clock, no enable.
//                Ports:
//                  clk     in  1      rising-edge clock
//                  rst_n   in  1      asynchronous active-low reset
//                  a       in  32     operand A (rs)
//                  b       in  32     operand B (rt / imm / shift amount)
//                  ALUSel  in  4      operation select
//                  result  out 32     registered result
//                  sign    out 1      registered result[31]
//                  zero    out 1      registered (result == 0)
//                  carry   out 1      registered per-operation carry
//                Build option: define ALU_SUB_EN to enable opcode 0111 (SUB);
//                otherwise 0111 is treated as an unused code.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUSel,
    output logic [WIDTH-1:0] result,
    output logic             sign,
    output logic             zero,
    output logic             carry
);

    // ------------------------------------------------------------------
    // Arithmetic: 33-bit sums so bit 32 is the carry out
    // ------------------------------------------------------------------
    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_comp;

    assign w_add  = {1'b0, a} + {1'b0, b};
    assign w_comp = {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_SUB_EN
    // a + ~b + 1: bit 32 set means no borrow (a >= b unsigned)
    logic [WIDTH:0] w_sub;
    assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
`endif

    // ------------------------------------------------------------------
    // Shifter
    // ------------------------------------------------------------------
    shift_mode_t      w_sh_mode;
    logic [WIDTH-1:0] w_shifted;
    logic             w_sh_out;

    always_comb begin
        w_sh_mode = SH_LL;
        if (ALUSel == ALU_SHRL)
            w_sh_mode = SH_RL;
        else if (ALUSel == ALU_SHRA)
            w_sh_mode = SH_RA;
    end

    alu_shifter u_shifter (
        .a       (a),
        .amount  (b[4:0]),
        .mode    (w_sh_mode),
        .shifted (w_shifted),
        .out_bit (w_sh_out)
    );

    // ------------------------------------------------------------------
    // DIFF: index of lowest differing bit, 32 when operands are equal.
    // Scanning high to low lets the lowest set bit win.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_diff;

    assign w_xor = a ^ b;

    always_comb begin
        w_diff = WIDTH'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_xor[i])
                w_diff = WIDTH'(i);
        end
    end

    // ------------------------------------------------------------------
    // Operation mux
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (ALUSel)
            ALU_ADD: begin
                w_result = w_add[WIDTH-1:0];
                w_carry  = w_add[WIDTH];
            end
            ALU_COMP: begin
                w_result = w_comp[WIDTH-1:0];
                w_carry  = w_comp[WIDTH];
            end
            ALU_AND: begin
                w_result = a & b;
            end
            ALU_XOR: begin
                w_result = w_xor;
            end
            ALU_SHLL, ALU_SHRL, ALU_SHRA: begin
                w_result = w_shifted;
                w_carry  = w_sh_out;
            end
`ifdef ALU_SUB_EN
            ALU_SUB: begin
                w_result = w_sub[WIDTH-1:0];
                w_carry  = w_sub[WIDTH];
            end
`endif
            ALU_DIFF: begin
                w_result = w_diff;
            end
            default: begin
                w_result = '0;
                w_carry  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register; flags always follow the newly loaded result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            sign   <= 1'b0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else begin
            result <= w_result;
            sign   <= w_result[WIDTH-1];
            zero   <= (w_result == '0);
            carry  <= w_carry;
        end
    end

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Directed self-checking bench for alu. Applies hand-computed
//                vectors and checks result and flags one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUSel;
    logic [31:0] result;
    logic        sign;
    logic        zero;
    logic        carry;

    int checks;
    int errors;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .ALUSel (ALUSel),
        .result (result),
        .sign   (sign),
        .zero   (zero),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all four outputs against expected values
    task automatic chk_all(input string tag, input logic [31:0] r,
                           input logic s, input logic z, input logic c);
        chk({tag, ".result"}, result, r);
        chk({tag, ".sign"},   {31'd0, sign},  {31'd0, s});
        chk({tag, ".zero"},   {31'd0, zero},  {31'd0, z});
        chk({tag, ".carry"},  {31'd0, carry}, {31'd0, c});
    endtask

    // Apply operands before an edge, then sample 1 time unit after it
    task automatic step(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        ALUSel = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 32'd0;
        b      = 32'd0;
        ALUSel = 4'b0000;

        // Reset state: op ADD 0+0 pending, outputs must be held at 0
        @(posedge clk);
        #1;
        chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD
        step(4'b0000, 32'hFFFF_FFFF, 32'd1392);
        chk_all("add_wrap", 32'd1391, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 32'd100, 32'd0);
        chk_all("add_b0", 32'd100, 1'b0, 1'b0, 1'b0);

        // COMP
        step(4'b0001, 32'd77, 32'd2);
        chk_all("comp_2", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 32'd77, 32'd0);
        chk_all("comp_0", 32'd0, 1'b0, 1'b1, 1'b1);

        // AND / XOR
        step(4'b0010, 32'd199, 32'd30);
        chk_all("and", 32'd6, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 32'd199, 32'd0);
        chk_all("and_zero", 32'd0, 1'b0, 1'b1, 1'b0);
        step(4'b0011, 32'd939, 32'd104);
        chk_all("xor", 32'd963, 1'b0, 1'b0, 1'b0);
        step(4'b0011, 32'd939, 32'd0);
        chk_all("xor_b0", 32'd939, 1'b0, 1'b0, 1'b0);

        // Shifts
        step(4'b0100, 32'd100, 32'd2);
        chk_all("shll", 32'd400, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 32'h8000_0001, 32'd1);
        chk_all("shll_cout", 32'd2, 1'b0, 1'b0, 1'b1);
        step(4'b0100, 32'h4000_0000, 32'd2);
        chk_all("shll_lastout", 32'd0, 1'b0, 1'b1, 1'b1);
        step(4'b0101, 32'd100, 32'd2);
        chk_all("shrl", 32'd25, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 32'd5, 32'd1);
        chk_all("shrl_cout", 32'd2, 1'b0, 1'b0, 1'b1);
        step(4'b0101, 32'h0000_0100, 32'hFFFF_FFE1);
        chk_all("shrl_bhigh", 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 32'hFFFF_FFFF, 32'd0);
        chk_all("shrl_n0", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step(4'b0110, 32'd100, 32'd4);
        chk_all("shra", 32'd6, 1'b0, 1'b0, 1'b0);
        step(4'b0110, 32'h8000_0000, 32'd4);
        chk_all("shra_neg", 32'hF800_0000, 1'b1, 1'b0, 1'b0);
        step(4'b0110, 32'h8000_0008, 32'd4);
        chk_all("shra_cout", 32'hF800_0000, 1'b1, 1'b0, 1'b1);
        step(4'b0110, 32'h8000_0000, 32'd31);
        chk_all("shra_31", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // DIFF
        step(4'b1001, 32'd100, 32'd228);
        chk_all("diff", 32'd7, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 32'd5, 32'd5);
        chk_all("diff_eq", 32'd32, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 32'h0000_0000, 32'h0000_0001);
        chk_all("diff_bit0", 32'd0, 1'b0, 1'b1, 1'b0);
        step(4'b1001, 32'h8000_0000, 32'h0000_0000);
        chk_all("diff_bit31", 32'd31, 1'b0, 1'b0, 1'b0);

        // SUB (0111) in both builds
`ifdef ALU_SUB_EN
        step(4'b0111, 32'd5, 32'd7);
        chk_all("sub_neg", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        step(4'b0111, 32'd7, 32'd7);
        chk_all("sub_eq", 32'd0, 1'b0, 1'b1, 1'b1);
`else
        step(4'b0111, 32'd5, 32'd7);
        chk_all("op0111_unused", 32'd0, 1'b0, 1'b1, 1'b0);
`endif

        // Unused codes
        step(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_all("op1000", 32'd0, 1'b0, 1'b1, 1'b0);

        // Non-zero state before the asynchronous reset
        step(4'b0001, 32'd0, 32'd1);
        chk_all("pre_reset", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges
        @(negedge clk);
        ALUSel = 4'b1111;
        a      = 32'd123;
        b      = 32'd456;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset_op1111", 32'd0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: one result per cycle after reset release
        step(4'b0000, 32'd1, 32'd2);
        chk_all("b2b_add", 32'd3, 1'b0, 1'b0, 1'b0);
        step(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        chk_all("b2b_xor", 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
